// File: rtl/bitonic_sorter.sv
// Bitonic sorting network over NUM_WAY unsigned keys, ascending by way index.
// Define BITONIC_SORTER_PIPELINE_EN to register every compare-exchange stage; otherwise one output register.
module bitonic_sorter #(
    parameter int unsigned SINGLE_WAY_WIDTH_IN_BITS = 4,
    parameter int unsigned NUM_WAY                  = 16
) (
    input  logic                                         clk_in,
    input  logic                                         reset_in,
    input  logic [SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY-1:0] pre_sort_flatted_in,
    output logic [SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY-1:0] post_sort_flatted_out
);

    localparam int unsigned W          = SINGLE_WAY_WIDTH_IN_BITS;
    localparam int unsigned LOG_N      = $clog2(NUM_WAY);
    localparam int unsigned NUM_STAGES = LOG_N * (LOG_N + 1) / 2;

    // Packed layout puts way i at bits [i*W +: W], matching the flat ports.
    typedef logic [NUM_WAY-1:0][W-1:0] vec_t;

    // One compare-exchange stage: merge size 2^p, partner distance 2^(q-1).
    function automatic vec_t cx_stage(input vec_t d, input int unsigned p, input int unsigned q);
        vec_t              r;
        int unsigned       k;
        int unsigned       j;
        logic [LOG_N-1:0]  ii;
        logic [LOG_N-1:0]  mm;
        r = d;
        k = 1 << p;
        j = 1 << (q - 1);
        for (int unsigned i = 0; i < NUM_WAY; i++) begin
            ii = i[LOG_N-1:0];
            mm = ii ^ j[LOG_N-1:0];
            if (mm > ii) begin
                if (((i & k) == 0) ? (d[ii] > d[mm]) : (d[ii] < d[mm])) begin
                    r[ii] = d[mm];
                    r[mm] = d[ii];
                end
            end
        end
        return r;
    endfunction

`ifdef BITONIC_SORTER_PIPELINE_EN

    localparam int unsigned SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    vec_t pipe_q [NUM_STAGES];
    vec_t pipe_d [NUM_STAGES];

    always_comb begin
        logic [SW-1:0] s;
        s = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            pipe_d[i] = '0;
        end
        for (int unsigned p = 1; p <= LOG_N; p++) begin
            for (int unsigned q = p; q > 0; q--) begin
                if (s == '0) begin
                    pipe_d[s] = cx_stage(vec_t'(pre_sort_flatted_in), p, q);
                end else begin
                    pipe_d[s] = cx_stage(pipe_q[s - 1'b1], p, q);
                end
                s = s + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign post_sort_flatted_out = pipe_q[NUM_STAGES-1];

`else

    vec_t net;
    vec_t out_q;

    always_comb begin
        net = vec_t'(pre_sort_flatted_in);
        for (int unsigned p = 1; p <= LOG_N; p++) begin
            for (int unsigned q = p; q > 0; q--) begin
                net = cx_stage(net, p, q);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            out_q <= '0;
        end else begin
            out_q <= net;
        end
    end

    assign post_sort_flatted_out = out_q;

`endif

endmodule

// File: tb/tb_bitonic_sorter.sv
// Scoreboard bench for bitonic_sorter (16 ways x 4 bits); latency follows BITONIC_SORTER_PIPELINE_EN.
module tb_bitonic_sorter;

    localparam int N = 16;
    localparam int W = 4;
`ifdef BITONIC_SORTER_PIPELINE_EN
    localparam int LAT = 10;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] din;
    logic [63:0] dout;

    logic [63:0] exp_q [$];
    string       tag_q [$];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bitonic_sorter #(
        .SINGLE_WAY_WIDTH_IN_BITS(W),
        .NUM_WAY                 (N)
    ) dut (
        .clk_in               (clk),
        .reset_in             (rst),
        .pre_sort_flatted_in  (din),
        .post_sort_flatted_out(dout)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_sort(input logic [63:0] v);
        logic [3:0]  a [16];
        logic [3:0]  t;
        logic [63:0] r;
        for (int i = 0; i < N; i++) a[i] = v[i*W +: W];
        for (int i = 1; i < N; i++) begin
            for (int j = i; j > 0; j--) begin
                if (a[j-1] > a[j]) begin
                    t      = a[j];
                    a[j]   = a[j-1];
                    a[j-1] = t;
                end
            end
        end
        for (int i = 0; i < N; i++) r[i*W +: W] = a[i];
        return r;
    endfunction

    // Drive one vector (or a reset), clock once, then compare the output due this cycle.
    task automatic cycle(input string tag, input logic r, input logic [63:0] v,
                         input logic [63:0] e);
        logic [63:0] exp;
        string       etag;
        rst = r;
        din = v;
        @(posedge clk);
        #1;
        if (r) begin
            exp_q.delete();
            tag_q.delete();
            for (int i = 0; i < LAT - 1; i++) begin
                exp_q.push_back(64'h0);
                tag_q.push_back("post_reset_zero");
            end
            check_eq("reset", dout, 64'h0);
        end else begin
            exp_q.push_back(e);
            tag_q.push_back(tag);
            exp  = exp_q.pop_front();
            etag = tag_q.pop_front();
            check_eq(etag, dout, exp);
        end
    endtask

    task automatic rand_cycle(input string tag);
        logic [63:0] v;
        v = {$urandom(), $urandom()};
        cycle(tag, 1'b0, v, ref_sort(v));
    endtask

    initial begin
        rst = 1'b1;
        din = 64'h0;
        cycle("reset", 1'b1, 64'h0, 64'h0);
        cycle("reset", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);

        // Directed vectors back to back; hex digits are way 15 .. way 0.
        cycle("reverse",  1'b0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210);
        cycle("rev_dups", 1'b0, 64'h0022_4466_88BB_DDFF, 64'hFFDD_BB88_6644_2200);
        cycle("rand_dup", 1'b0, 64'h87B4_ACFA_03F5_4892, 64'hFFCB_AA98_8754_4320);
        cycle("sorted",   1'b0, 64'hFEDC_BA98_7654_3210, 64'hFEDC_BA98_7654_3210);
        for (int i = 0; i < LAT + 2; i++) begin
            cycle("all_seven", 1'b0, 64'h7777_7777_7777_7777, 64'h7777_7777_7777_7777);
        end
        cycle("max_min", 1'b0, 64'h0000_0000_0000_000F, 64'hF000_0000_0000_0000);

        for (int i = 0; i < 20; i++) rand_cycle("random_a");

        // Mid-stream reset discards everything in flight.
        cycle("reset", 1'b1, 64'h1234_5678_9ABC_DEF0, 64'h0);
        cycle("after_rst", 1'b0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210);
        for (int i = 0; i < 12; i++) rand_cycle("random_b");

        for (int i = 0; i < LAT + 1; i++) cycle("flush", 1'b0, 64'h0, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bitonic_sorter.md
BITONIC_SORTER -- requirements
Module: bitonic_sorter

Interface
REQ-001 SHALL have parameter SINGLE_WAY_WIDTH_IN_BITS, default 4: width of one unsigned key.
REQ-002 SHALL have parameter NUM_WAY, default 16: number of keys; power of 2, >= 2.
REQ-003 SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-004 SHALL have port clk_in, input, 1 bit: clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_in, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port pre_sort_flatted_in, input, SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY bits: unsorted keys; way i at bits [i*W +: W].
REQ-007 SHALL have port post_sort_flatted_out, output, SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY bits: sorted keys, same packing.

Function
REQ-008 SHALL implement a bitonic sorting network of log2(N)*(log2(N)+1)/2 compare-exchange stages, with N/2 comparators per stage; N=16 gives 10 stages.
REQ-009 SHALL sort ascending by way index: out way 0 is the minimum, and out way N-1 is the maximum.
REQ-010 SHALL compare keys as unsigned values; equal keys pass unchanged; no key is dropped or duplicated, so the output is a permutation of the input.
REQ-011 SHALL sample input on every rising clk_in edge with no handshake; a new vector may be presented each cycle.
REQ-012 SHALL have a latency of L cycles, per REQ-018/019, from the clock edge sampling an input vector to that vector's sorted result on post_sort_flatted_out.
REQ-013 SHALL, at full throughput, produce the sorted result of the vector sampled L cycles earlier, every cycle.
REQ-014 SHALL hold a constant input indefinitely and keep the output constant at its sorted value after L cycles.
REQ-015 SHALL drive post_sort_flatted_out directly from registers, with no combinational path from input to output.

Reset
REQ-016 SHALL clear every pipeline register and post_sort_flatted_out to all zeros on a rising clk_in edge with reset_in=1.
REQ-017 SHALL, when reset is asserted mid-operation, discard all in-flight vectors; the first valid output appears L cycles after the first non-reset sampling edge, and outputs before that are zero.

Configuration
REQ-018 SHALL, with macro BITONIC_SORTER_PIPELINE_EN defined, register after every compare-exchange stage: L = number of stages (10 for N=16).
REQ-019 SHALL, without BITONIC_SORTER_PIPELINE_EN, use a fully combinational network feeding a single output register: L = 1.

Verification
REQ-020 SHALL cover reverse order: ways 0..15 = F,E,...,0 -> after L cycles, ways 0..15 = 0,1,...,F.
REQ-021 SHALL cover reverse order with duplicates: ways 0..15 = F,F,D,D,B,B,8,8,6,6,4,4,2,2,0,0 -> ways 0..15 = 0,0,2,2,4,4,6,6,8,8,B,B,D,D,F,F.
REQ-022 SHALL cover random with duplicates: ways 0..15 = 2,9,8,4,5,F,3,0,A,F,C,A,4,B,7,8 -> 0,2,3,4,4,5,7,8,8,9,A,A,B,C,F,F.
REQ-023 SHALL cover already sorted and all-equal input (all 7) -> output identical to input.
REQ-024 SHALL cover back-to-back distinct vectors on consecutive cycles -> each sorted result appears exactly L cycles later, in order.
REQ-025 SHALL cover reset pulse mid-stream -> output all zeros on the next edge; the next vector's sorted result appears L cycles after reset deasserts; run under both macro settings.
